// File: rtl/gpr_wb_arbiter.sv
// Round-robin writeback arbiter (ALU/LSU -> single GPR write port) with a
// per-register pending-write scoreboard for read-after-write stall detection.
module gpr_wb_arbiter #(
  parameter int XLEN   = 64,
  parameter int PCNT_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_full,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic [4:0]      rd0_addr,
  output logic [XLEN-1:0] rd0_data,
  output logic            clk_en,
  output logic [31:0]     busy
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

  localparam logic [PCNT_W-1:0] CNT_MAX = '1;

  src_e                     last;
  logic                     contended;
  logic                     grant_alu;
  logic                     grant_lsu;
  logic                     accept;
  logic [4:0]               win_rd;
  logic [XLEN-1:0]          win_data;
  logic                     inc;
  logic [31:0][PCNT_W-1:0]  cnt_flat;

  // The source that lost the last contended cycle wins the next one.
  always_comb begin
    contended = alu_valid & lsu_valid;
    grant_alu = alu_valid & (~lsu_valid | (last == SRC_LSU));
    grant_lsu = lsu_valid & (~alu_valid | (last == SRC_ALU));
    accept    = grant_alu | grant_lsu;
    win_rd    = grant_lsu ? lsu_rd   : alu_rd;
    win_data  = grant_lsu ? lsu_data : alu_data;
  end

  assign alu_ready = alu_valid & grant_alu;
  assign lsu_ready = lsu_valid & grant_lsu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= SRC_ALU;
    end else if (contended) begin
      last <= grant_lsu ? SRC_LSU : SRC_ALU;
    end
  end

  // Results to x0 are accepted but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd0_addr <= 5'd0;
      rd0_data <= '0;
      clk_en   <= 1'b0;
    end else if (accept) begin
      rd0_addr <= win_rd;
      rd0_data <= win_data;
      clk_en   <= (win_rd != 5'd0);
    end else begin
      clk_en   <= 1'b0;
    end
  end

  assign issue_full = issue_valid & (issue_rd != 5'd0) & (cnt_flat[issue_rd] == CNT_MAX);
  assign inc        = issue_valid & (issue_rd != 5'd0) & ~issue_full;

  assign cnt_flat[0] = '0;
  assign busy[0]     = 1'b0;

  for (genvar n = 1; n < 32; n++) begin : g_cnt
    logic              inc_n;
    logic              dec_n;
    logic [PCNT_W-1:0] cnt_q;

    assign inc_n = inc & (issue_rd == 5'(n));
    assign dec_n = clk_en & (rd0_addr == 5'(n));

    // A decrement on an empty counter is a protocol error; hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (inc_n && !dec_n) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (dec_n && !inc_n && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end

    assign cnt_flat[n] = cnt_q;
    assign busy[n]     = (cnt_q != '0);
  end

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(clk_en && (cnt_flat[rd0_addr] == '0)));

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: expected writes go into a queue that a
// monitor drains on every register-file write; other outputs checked inline.
module tb_gpr_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_full;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic [4:0]  rd0_addr;
  logic [63:0] rd0_data;
  logic        clk_en;
  logic [31:0] busy;

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  gpr_wb_arbiter #(.XLEN(64), .PCNT_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_full  (issue_full),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .rd0_addr    (rd0_addr),
    .rd0_data    (rd0_data),
    .clk_en      (clk_en),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [4:0] ird,
                               input logic av, input logic [4:0] ard, input logic [63:0] ad,
                               input logic lv, input logic [4:0] lrd, input logic [63:0] ld);
    issue_valid = iv;
    issue_rd    = ird;
    alu_valid   = av;
    alu_rd      = ard;
    alu_data    = ad;
    lsu_valid   = lv;
    lsu_rd      = lrd;
    lsu_data    = ld;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectWrite(input logic [4:0] addr, input logic [63:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic issueReg(input logic [4:0] rd);
    applyStimulus(1'b1, rd, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    tick();
  endtask

  // Every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && clk_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL unexpected_write actual=%0h:%0h required=none", rd0_addr, rd0_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("wr_addr", 64'(rd0_addr), 64'(e.addr));
        checkOutput("wr_data", rd0_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [63:0] alu_d [4];
  logic [63:0] lsu_d [4];
  logic        lsu_wins [4];

  initial begin
    alu_d    = '{64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0001,
                 64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0002};
    lsu_d    = '{64'h5555_0000_0000_0001, 64'h5555_0000_0000_0002,
                 64'h5555_0000_0000_0002, 64'h5555_0000_0000_0003};
    lsu_wins = '{1'b1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b1;
    idle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_clk_en", 64'(clk_en), 64'd0);
    checkOutput("rst_addr", 64'(rd0_addr), 64'd0);
    checkOutput("rst_data", rd0_data, 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single ALU result to r5
    applyStimulus(1'b1, 5'd5, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    @(negedge clk);
    checkOutput("t1_issue_full", 64'(issue_full), 64'd0);
    checkOutput("t1_busy_c0", 64'(busy), 64'd0);
    tick();
    idle();
    @(negedge clk);
    checkOutput("t1_busy_c1", 64'(busy), 64'h20);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);
    expectWrite(5'd5, 64'h1234);
    @(negedge clk);
    checkOutput("t1_alu_ready", 64'(alu_ready), 64'd1);
    checkOutput("t1_lsu_ready", 64'(lsu_ready), 64'd0);
    tick();
    idle();
    @(negedge clk);
    checkOutput("t1_clk_en_c3", 64'(clk_en), 64'd1);
    checkOutput("t1_busy_c3", 64'(busy), 64'h20);
    tick();
    @(negedge clk);
    checkOutput("t1_busy_c4", 64'(busy), 64'd0);
    checkOutput("t1_clk_en_c4", 64'(clk_en), 64'd0);

    // Contention: r1 from ALU, r2 from LSU, loser holds its payload
    tick();
    issueReg(5'd1);
    issueReg(5'd1);
    issueReg(5'd2);
    issueReg(5'd2);
    issueReg(5'd2);
    idle();
    @(negedge clk);
    checkOutput("t2_busy_pre", 64'(busy), 64'h6);
    for (int c = 0; c < 4; c++) begin
      tick();
      applyStimulus(1'b0, 5'd0, 1'b1, 5'd1, alu_d[c], 1'b1, 5'd2, lsu_d[c]);
      if (lsu_wins[c]) expectWrite(5'd2, lsu_d[c]);
      else             expectWrite(5'd1, alu_d[c]);
      @(negedge clk);
      checkOutput($sformatf("t2_lsu_ready_%0d", c), 64'(lsu_ready), 64'(lsu_wins[c]));
      checkOutput($sformatf("t2_alu_ready_%0d", c), 64'(alu_ready), 64'(!lsu_wins[c]));
    end
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd2, lsu_d[3]);
    expectWrite(5'd2, lsu_d[3]);
    @(negedge clk);
    checkOutput("t2_lsu_ready_tail", 64'(lsu_ready), 64'd1);
    tick();
    idle();
    tick();
    @(negedge clk);
    checkOutput("t2_busy_post", 64'(busy), 64'd0);

    // LSU result to x0 is consumed without a write
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hDEAD);
    @(negedge clk);
    checkOutput("t3_lsu_ready", 64'(lsu_ready), 64'd1);
    tick();
    idle();
    @(negedge clk);
    checkOutput("t3_clk_en", 64'(clk_en), 64'd0);
    checkOutput("t3_busy", 64'(busy), 64'd0);

    // Saturate r7, then drain with three writes
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd7, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      @(negedge clk);
      checkOutput($sformatf("t4_full_%0d", i), 64'(issue_full), 64'd0);
      tick();
    end
    applyStimulus(1'b1, 5'd7, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    @(negedge clk);
    checkOutput("t4_full_4th", 64'(issue_full), 64'd1);
    tick();
    idle();
    @(negedge clk);
    checkOutput("t4_full_idle", 64'(issue_full), 64'd0);
    checkOutput("t4_busy_sat", 64'(busy), 64'h80);
    for (int i = 0; i < 3; i++) begin
      tick();
      applyStimulus(1'b0, 5'd0, 1'b1, 5'd7, 64'h700 + 64'(i), 1'b0, 5'd0, 64'd0);
      expectWrite(5'd7, 64'h700 + 64'(i));
    end
    tick();
    idle();
    @(negedge clk);
    checkOutput("t4_busy_w3", 64'(busy), 64'h80);
    tick();
    @(negedge clk);
    checkOutput("t4_busy_w4", 64'(busy), 64'd0);

    // Issue and commit on r9 in the same cycle
    tick();
    issueReg(5'd9);
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'd0);
    expectWrite(5'd9, 64'h99);
    tick();
    applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    @(negedge clk);
    checkOutput("t5_clk_en", 64'(clk_en), 64'd1);
    checkOutput("t5_full", 64'(issue_full), 64'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd9, 64'h9A, 1'b0, 5'd0, 64'd0);
    expectWrite(5'd9, 64'h9A);
    @(negedge clk);
    checkOutput("t5_busy_same", 64'(busy), 64'h200);
    tick();
    idle();
    tick();
    @(negedge clk);
    checkOutput("t5_busy_drain", 64'(busy), 64'd0);

    // Asynchronous reset mid-stream, then first contention goes to the LSU
    tick();
    issueReg(5'd1);
    issueReg(5'd2);
    issueReg(5'd7);
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0);
    expectWrite(5'd7, 64'h77);
    @(negedge clk);
    checkOutput("t6_busy_pre", 64'(busy), 64'h86);
    tick();
    idle();
    @(negedge clk);
    checkOutput("t6_clk_en_pre", 64'(clk_en), 64'd1);
    checkOutput("t6_busy_inflight", 64'(busy), 64'h86);
    #2 rst_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44);
    #1;
    checkOutput("t6_rst_clk_en", 64'(clk_en), 64'd0);
    checkOutput("t6_rst_addr", 64'(rd0_addr), 64'd0);
    checkOutput("t6_rst_data", rd0_data, 64'd0);
    checkOutput("t6_rst_busy", 64'(busy), 64'd0);
    checkOutput("t6_rst_lsu_ready", 64'(lsu_ready), 64'd1);
    checkOutput("t6_rst_alu_ready", 64'(alu_ready), 64'd0);
    exp_q.delete();
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    issueReg(5'd3);
    issueReg(5'd4);
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44);
    expectWrite(5'd4, 64'h44);
    @(negedge clk);
    checkOutput("t6_post_lsu_ready", 64'(lsu_ready), 64'd1);
    checkOutput("t6_post_alu_ready", 64'(alu_ready), 64'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 64'd0);
    expectWrite(5'd3, 64'h33);
    @(negedge clk);
    checkOutput("t6_post_alu_ready2", 64'(alu_ready), 64'd1);
    tick();
    idle();
    tick();
    @(negedge clk);
    checkOutput("t6_busy_end", 64'(busy), 64'd0);

    tick();
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
